// File: rtl/cursor_ctrl_rpt.sv
// Cursor position controller: four debounced active-low keys move (cursor_x, cursor_y)
// by a runtime step, with hold-to-repeat, edge wrap/clamp and synchronous recenter.
module cursor_ctrl_rpt #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int POS_W        = 11,
    parameter int STEP_W       = 5,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter bit WRAP         = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_n,
    input  logic              recenter,
    input  logic [STEP_W-1:0] step,
    output logic [POS_W-1:0]  cursor_x,
    output logic [POS_W-1:0]  cursor_y,
    output logic              moved
);

    localparam int PW1     = POS_W + 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam logic [PW1-1:0]   H_RES_W    = PW1'(H_RES);
    localparam logic [PW1-1:0]   V_RES_W    = PW1'(V_RES);
    localparam logic [POS_W-1:0] X_CENTRE   = POS_W'(H_RES / 2);
    localparam logic [POS_W-1:0] Y_CENTRE   = POS_W'(V_RES / 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [1:0] KEY_RIGHT = 2'd0;
    localparam logic [1:0] KEY_LEFT  = 2'd1;
    localparam logic [1:0] KEY_DOWN  = 2'd2;
    localparam logic [1:0] KEY_UP    = 2'd3;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_q;
    logic [DB_W-1:0]  db_cnt_q [4];

    logic [1:0]       state_q, state_d;
    logic [1:0]       active_q, active_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             block_q, block_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic             moved_q, moved_d;

    logic [3:0]       pressed;
    logic             any_pressed;
    logic [1:0]       pick;
    logic [1:0]       mv_key;
    logic             do_move;
    logic [PW1-1:0]   step_ext, step_h, step_v;

    function automatic logic [POS_W-1:0] move_dec(input logic [PW1-1:0] pos,
                                                  input logic [PW1-1:0] stp,
                                                  input logic [PW1-1:0] res);
        logic [PW1-1:0] r;
        if (pos < stp) begin
            if (WRAP) r = pos + res - stp;
            else      r = '0;
        end else begin
            r = pos - stp;
        end
        return r[POS_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] move_inc(input logic [PW1-1:0] pos,
                                                  input logic [PW1-1:0] stp,
                                                  input logic [PW1-1:0] res);
        logic [PW1-1:0] sum;
        logic [PW1-1:0] r;
        sum = pos + stp;
        if (sum >= res) begin
            if (WRAP) r = sum - res;
            else      r = res - 1'b1;
        end else begin
            r = sum;
        end
        return r[POS_W-1:0];
    endfunction

    // Input stage: 2-FF synchroniser, then per-key stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            deb_q   <= 4'hF;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            for (int k = 0; k < 4; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    deb_q[k]    <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign pressed     = ~deb_q;
    assign any_pressed = |pressed;

    always_comb begin
        pick = KEY_RIGHT;
        if (pressed[KEY_UP])        pick = KEY_UP;
        else if (pressed[KEY_DOWN]) pick = KEY_DOWN;
        else if (pressed[KEY_LEFT]) pick = KEY_LEFT;
    end

    // A step at or beyond the axis resolution behaves as resolution-1
    assign step_ext = PW1'(step);
    assign step_h   = (step_ext >= H_RES_W) ? H_RES_W - 1'b1 : step_ext;
    assign step_v   = (step_ext >= V_RES_W) ? V_RES_W - 1'b1 : step_ext;

    // Control stage: press/delay/repeat sequencing and position update
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        rpt_cnt_d = rpt_cnt_q;
        block_d   = block_q;
        x_d       = x_q;
        y_d       = y_q;
        moved_d   = 1'b0;
        do_move   = 1'b0;
        mv_key    = active_q;

        if (recenter) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
            block_d   = 1'b1;
            x_d       = X_CENTRE;
            y_d       = Y_CENTRE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rpt_cnt_d = '0;
                    // After a recenter, keys must all be released before a new press counts
                    if (block_q) begin
                        if (!any_pressed) block_d = 1'b0;
                    end else if (any_pressed) begin
                        do_move  = 1'b1;
                        mv_key   = pick;
                        active_d = pick;
                        state_d  = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!pressed[active_q]) begin
                        state_d   = ST_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        do_move   = 1'b1;
                        state_d   = ST_REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!pressed[active_q]) begin
                        state_d   = ST_IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == RATE_LAST) begin
                        do_move   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase

            if (do_move && (step != '0)) begin
                moved_d = 1'b1;
                case (mv_key)
                    KEY_UP:   y_d = move_dec(PW1'(y_q), step_v, V_RES_W);
                    KEY_DOWN: y_d = move_inc(PW1'(y_q), step_v, V_RES_W);
                    KEY_LEFT: x_d = move_dec(PW1'(x_q), step_h, H_RES_W);
                    default:  x_d = move_inc(PW1'(x_q), step_h, H_RES_W);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            active_q  <= KEY_RIGHT;
            rpt_cnt_q <= '0;
            block_q   <= 1'b0;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            moved_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            rpt_cnt_q <= rpt_cnt_d;
            block_q   <= block_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moved_q   <= moved_d;
        end
    end

    assign cursor_x = x_q;
    assign cursor_y = y_q;
    assign moved    = moved_q;

endmodule

// File: tb/tb_cursor_ctrl_rpt.sv
// Directed bench for cursor_ctrl_rpt: a wrapping and a saturating instance share one
// stimulus stream; expected positions and move timing are hand-computed constants.
module tb_cursor_ctrl_rpt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic        recenter = 1'b0;
    logic [4:0]  step = 5'd16;

    logic [10:0] w_x, w_y, s_x, s_y;
    logic        w_mv, s_mv;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int mv_w   = 0;
    int mv_s   = 0;

    always #5 clk = ~clk;

    cursor_ctrl_rpt #(
        .H_RES(640), .V_RES(480), .POS_W(11), .STEP_W(5),
        .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .WRAP(1'b1)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .recenter(recenter), .step(step),
        .cursor_x(w_x), .cursor_y(w_y), .moved(w_mv)
    );

    cursor_ctrl_rpt #(
        .H_RES(640), .V_RES(480), .POS_W(11), .STEP_W(5),
        .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .WRAP(1'b0)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .recenter(recenter), .step(step),
        .cursor_x(s_x), .cursor_y(s_y), .moved(s_mv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (w_mv === 1'b1) mv_w++;
            if (s_mv === 1'b1) mv_s++;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        key_n    = 4'hF;
        recenter = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        mv_w = 0;
        mv_s = 0;
    endtask

    task automatic press_release(input int k);
        key_n[k] = 1'b0;
        tick(10);
        key_n = 4'hF;
        tick(10);
    endtask

    initial begin
        int k;
        logic exp_mv;

        // Reset values while rst_n is held low
        tick(2);
        check("rst_x", w_x, 320);
        check("rst_y", w_y, 240);
        check("rst_moved", w_mv, 0);
        check("rst_sat_x", s_x, 320);

        // 1: right held 10 cycles -> one move to (336,240)
        do_reset();
        key_n = 4'b1110;
        tick(10);
        key_n = 4'hF;
        tick(20);
        check("t1_x", w_x, 336);
        check("t1_y", w_y, 240);
        check("t1_pulses", mv_w, 1);

        // 2: edge behaviour, wrapping vs saturating
        do_reset();
        step = 5'd29;
        for (int i = 0; i < 8; i++) press_release(3);
        check("t2_w_y8", w_y, 8);
        check("t2_s_y8", s_y, 8);
        step = 5'd16;
        press_release(3);
        check("t2_w_up_wrap", w_y, 472);
        check("t2_s_up_clamp", s_y, 0);
        step = 5'd31;
        for (int i = 0; i < 10; i++) press_release(0);
        check("t2_w_x630", w_x, 630);
        check("t2_s_x630", s_x, 630);
        step = 5'd16;
        press_release(0);
        check("t2_s_right_clamp", s_x, 639);
        check("t2_w_right_wrap", w_x, 6);

        // 3: hold down; moves at edges 7, 27, 35, 43, 51, 59 after the press
        do_reset();
        step  = 5'd16;
        key_n = 4'b1011;
        k = 0;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk);
            #1;
            exp_mv = (c == 7) || (c == 27) || (c == 35) || (c == 43) || (c == 51) || (c == 59);
            check("t3_moved", w_mv, exp_mv);
            if (exp_mv) begin
                k++;
                check("t3_y", w_y, 240 + 16 * k);
            end
            if (c == 60) key_n = 4'hF;
        end
        check("t3_final_y", w_y, 336);
        check("t3_final_x", w_x, 320);

        // 4: glitch rejected; up+right together moves only y
        do_reset();
        key_n = 4'b1101;
        tick(2);
        key_n = 4'hF;
        tick(15);
        check("t4_glitch_pulses", mv_w, 0);
        check("t4_glitch_x", w_x, 320);
        key_n = 4'b0110;
        tick(10);
        key_n = 4'hF;
        tick(20);
        check("t4_combo_y", w_y, 224);
        check("t4_combo_x", w_x, 320);
        check("t4_combo_pulses", mv_w, 1);

        // 5: recenter during repeat, coinciding with a due repeat move
        do_reset();
        key_n = 4'b1101;
        tick(34);
        check("t5_before_x", w_x, 288);
        recenter = 1'b1;
        tick(1);
        check("t5_rc_x", w_x, 320);
        check("t5_rc_y", w_y, 240);
        check("t5_rc_moved", w_mv, 0);
        recenter = 1'b0;
        mv_w = 0;
        tick(40);
        check("t5_held_pulses", mv_w, 0);
        check("t5_held_x", w_x, 320);
        key_n = 4'hF;
        tick(10);
        mv_w = 0;
        key_n = 4'b1101;
        tick(10);
        key_n = 4'hF;
        tick(20);
        check("t5_repress_x", w_x, 304);
        check("t5_repress_pulses", mv_w, 1);

        // 6: zero step never moves; async reset mid-repeat
        do_reset();
        step  = 5'd0;
        key_n = 4'b1110;
        tick(60);
        check("t6_step0_pulses", mv_w, 0);
        check("t6_step0_x", w_x, 320);
        check("t6_step0_y", w_y, 240);
        key_n = 4'hF;
        tick(10);
        step  = 5'd16;
        key_n = 4'b1110;
        tick(40);
        check("t6_repeat_x", w_x, 368);
        rst_n = 1'b0;
        #1;
        check("t6_rst_x", w_x, 320);
        check("t6_rst_y", w_y, 240);
        check("t6_rst_moved", w_mv, 0);
        tick(2);
        rst_n = 1'b1;
        mv_w = 0;
        tick(3);
        check("t6_release_pulses", mv_w, 0);
        check("t6_release_x", w_x, 320);
        key_n = 4'hF;
        tick(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
